// File: rtl/multiplier32bit_seq_if.sv
// Request/response bundle for the sequential shift-add multiplier.
// Handshake: start_mult is sampled on every rising edge and accepted only while
// idle (mult_active=0); operands are captured on that edge. mult_active stays
// high until the completion edge, which raises mult_done for exactly one cycle
// together with the updated product/result/overflow.
interface multiplier32bit_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start_mult;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     result;
    logic                 overflow;
    logic                 mult_active;
    logic                 mult_done;
    logic [1:0]           dbg_state;

    modport master (
        output start_mult, multiplicand, multiplier,
        input  product, result, overflow, mult_active, mult_done, dbg_state
    );

    modport slave (
        input  start_mult, multiplicand, multiplier,
        output product, result, overflow, mult_active, mult_done, dbg_state
    );
endinterface

// File: rtl/multiplier32bit_seq.sv
// Radix-2 shift-add unsigned multiplier, one partial product per clock,
// with a fixed-point right shift and saturation on the registered result.
module multiplier32bit_seq #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    multiplier32bit_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    // Holds the multiplier bits still to be consumed and, from the top,
    // the low half of the product as it shifts in.
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] full;
    logic [2*WIDTH-1:0] scaled;

    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        full   = {acc_hi, acc_lo};
        scaled = full >> FRAC_BITS;
    end

    assign bus.dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            mcand           <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            bus.product     <= '0;
            bus.result      <= '0;
            bus.overflow    <= 1'b0;
            bus.mult_active <= 1'b0;
            bus.mult_done   <= 1'b0;
        end else begin
            bus.mult_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_mult) begin
                        mcand           <= bus.multiplicand;
                        acc_lo          <= bus.multiplier;
                        acc_hi          <= '0;
                        cnt             <= CW'(WIDTH);
                        bus.mult_active <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    // Carry out of the add lands in acc_hi's MSB through the shift.
                    acc_hi <= sum[WIDTH:1];
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.product <= full;
                    if (|scaled[2*WIDTH-1:WIDTH]) begin
                        bus.result   <= '1;
                        bus.overflow <= 1'b1;
                    end else begin
                        bus.result   <= scaled[WIDTH-1:0];
                        bus.overflow <= 1'b0;
                    end
                    bus.mult_done   <= 1'b1;
                    bus.mult_active <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplier32bit_seq.sv
// Self-checking bench: two instances (FRAC_BITS 0 and 16) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_multiplier32bit_seq;
    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [31:0]   a = '0;
    logic [31:0]   b = '0;

    multiplier32bit_seq_if #(.WIDTH(W)) if0 ();
    multiplier32bit_seq_if #(.WIDTH(W)) if16 ();

    assign if0.start_mult    = start;
    assign if0.multiplicand  = a;
    assign if0.multiplier    = b;
    assign if16.start_mult   = start;
    assign if16.multiplicand = a;
    assign if16.multiplier   = b;

    multiplier32bit_seq #(.WIDTH(W), .FRAC_BITS(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    multiplier32bit_seq #(.WIDTH(W), .FRAC_BITS(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout waiting on DUT at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [32:0] scale(input logic [63:0] p, input int fb);
        logic [63:0] s;
        s = p >> fb;
        if (s[63:32] != 32'd0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, s[31:0]};
    endfunction

    int          m_cnt   = -1;
    logic [31:0] m_a     = '0;
    logic [31:0] m_b     = '0;
    logic [63:0] m_prod  = '0;
    logic [31:0] m_res0  = '0;
    logic [31:0] m_res16 = '0;
    logic        m_ovf0  = 1'b0;
    logic        m_ovf16 = 1'b0;
    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;

    // Timing contract: accept edge, WIDTH+1 edges later the results appear with done.
    always @(posedge clk) begin
        if (reset) begin
            m_cnt = -1; m_prod = '0; m_res0 = '0; m_res16 = '0;
            m_ovf0 = 1'b0; m_ovf16 = 1'b0; m_active = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt < 0) begin
                if (start) begin
                    m_a = a; m_b = b; m_cnt = 0; m_active = 1'b1;
                end
            end else begin
                m_cnt++;
                if (m_cnt == W + 1) begin
                    m_prod = {32'd0, m_a} * {32'd0, m_b};
                    {m_ovf0, m_res0}   = scale(m_prod, 0);
                    {m_ovf16, m_res16} = scale(m_prod, 16);
                    m_done   = 1'b1;
                    m_active = 1'b0;
                    m_cnt    = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("active0",  if0.mult_active,  m_active);
            check("done0",    if0.mult_done,    m_done);
            check("product0", if0.product,      m_prod);
            check("result0",  if0.result,       m_res0);
            check("ovf0",     if0.overflow,     m_ovf0);
            check("active16", if16.mult_active, m_active);
            check("done16",   if16.mult_done,   m_done);
            check("product16",if16.product,     m_prod);
            check("result16", if16.result,      m_res16);
            check("ovf16",    if16.overflow,    m_ovf16);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [31:0] ai, input logic [31:0] bi, output int lat);
        @(negedge clk);
        start = 1'b1; a = ai; b = bi; lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0; a = $urandom; b = $urandom;
            end
            if (if0.mult_done) return;
        end
        timeout("do_op");
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (if0.mult_done) return;
        end
        timeout("wait_done");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!if0.mult_active) return;
        end
        timeout("wait_idle");
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if0.mult_done || if16.mult_done) cnt++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int cnt;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_product", if0.product, 64'd0);
        check("rst_result",  if0.result, 64'd0);
        check("rst_active",  if0.mult_active, 64'd0);
        check("rst_done",    if0.mult_done, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_op(32'd3, 32'd5, lat);
        check("lat_3x5",  lat, 64'd34);
        check("prod_3x5", if0.product, 64'd15);
        check("res_3x5",  if0.result, 64'd15);
        check("ovf_3x5",  if0.overflow, 64'd0);

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("pin_prod_ff", m_prod, 64'hFFFF_FFFE_0000_0001);
        check("prod_ff", if0.product, 64'hFFFF_FFFE_0000_0001);
        check("res_ff",  if0.result, 64'hFFFF_FFFF);
        check("ovf_ff",  if0.overflow, 64'd1);

        do_op(32'd0, 32'hFFFF_FFFF, lat);
        check("lat_zero",  lat, 64'd34);
        check("prod_zero", if0.product, 64'd0);
        check("ovf_zero",  if0.overflow, 64'd0);

        do_op(32'h0001_8000, 32'h0002_0000, lat);
        check("pin_res_q16", m_res16, 64'h0003_0000);
        check("prod_q16", if16.product, 64'h0000_0003_0000_0000);
        check("res_q16",  if16.result, 64'h0003_0000);
        check("ovf_q16",  if16.overflow, 64'd0);

        do_op(32'h0100_0000, 32'h0100_0000, lat);
        check("res_q16_sat", if16.result, 64'hFFFF_FFFF);
        check("ovf_q16_sat", if16.overflow, 64'd1);

        // Request and operand changes while busy must be ignored.
        @(negedge clk); start = 1'b1; a = 32'd7; b = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; a = 32'd2; b = 32'd2;
        @(negedge clk); start = 1'b0; a = 32'd5; b = 32'd11;
        wait_done(lat);
        check("prod_stale", if0.product, 64'd63);
        count_dones(40, cnt);
        check("dones_stale", cnt, 64'd0);

        // Reset mid-operation aborts without a completion.
        @(negedge clk); start = 1'b1; a = 32'd100; b = 32'd100;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_product", if0.product, 64'd0);
        check("abort_result",  if0.result, 64'd0);
        check("abort_ovf",     if0.overflow, 64'd0);
        check("abort_active",  if0.mult_active, 64'd0);
        count_dones(40, cnt);
        check("abort_dones", cnt, 64'd0);
        do_op(32'd6, 32'd7, lat);
        check("lat_after_abort",  lat, 64'd34);
        check("prod_after_abort", if0.product, 64'd42);

        // Held request gives back-to-back completions.
        @(negedge clk); start = 1'b1; a = 32'd2; b = 32'd3;
        wait_done(lat);
        check("held_prod_0", if0.product, 64'd6);
        for (int k = 1; k <= 2; k++) begin
            wait_done(lat);
            check("held_gap",  lat, 64'd34);
            check("held_prod", if0.product, 64'd6);
        end
        start = 1'b0;
        wait_idle();

        // Randomized operations with request/operand noise while busy.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rb;
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom_range(0, 32'h00FF_FFFF); rb = $urandom_range(0, 32'h00FF_FFFF); end
                2: begin ra = $urandom_range(0, 32'hFFFF); rb = $urandom; end
                default: begin ra = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom; rb = 32'd0; end
            endcase
            @(negedge clk); start = 1'b1; a = ra; b = rb;
            begin : noisy
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (if0.mult_done) begin
                        start = 1'b0;
                        disable noisy;
                    end
                    start = ($urandom_range(0, 7) == 0);
                    a = $urandom; b = $urandom;
                end
                timeout("random_op");
            end
            start = 1'b0;
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
